// File: rtl/sop_sweep_checker.sv
// Sweeps all 16 {a,b,c,d} vectors into the SOP stage, captures y into a truth table
// and reports mismatches against a golden mask. Result holds until the next accepted start.
module sop_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [15:0] EXPECTED      = 16'h7310
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        y_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  mismatch_cnt,
    output logic        pass
);

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] table_q, table_d;
    logic [4:0]  mism_q, mism_d;
    logic        pass_q, pass_d;
    logic        miss;
    logic [4:0]  mism_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            table_q <= '0;
            mism_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            mism_q  <= mism_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        table_d   = table_q;
        mism_d    = mism_q;
        pass_d    = pass_q;
        miss      = (y_in != EXPECTED[idx_q]);
        mism_next = mism_q + {4'd0, miss};

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = APPLY;
                    idx_d   = '0;
                    cnt_d   = '0;
                    table_d = '0;
                    mism_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            APPLY: begin
                if (cnt_q == SETTLE_LAST) begin
                    table_d[idx_q] = y_in;
                    mism_d         = mism_next;
                    cnt_d          = '0;
                    // pass uses mism_next so the last vector's miss is included
                    if (idx_q == 4'd15) begin
                        state_d = DONE;
                        pass_d  = (mism_next == 5'd0);
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign {a, b, c, d}  = idx_q;
    assign busy          = (state_q == APPLY);
    assign done          = (state_q == DONE);
    assign table_out     = table_q;
    assign mismatch_cnt  = mism_q;
    assign pass          = pass_q;

endmodule

// File: tb/tb_sop_sweep_checker.sv
// Directed bench: default-settle and zero-settle checkers around a behavioural SOP stage.
module tb_sop_sweep_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    int          ymode;
    int          sel;
    int          checks = 0;
    int          errors = 0;

    logic        a0, b0, c0, d0, y0, busy0, done0, pass0;
    logic [15:0] tbl0;
    logic [4:0]  mm0;
    logic        a1, b1, c1, d1, y1, busy1, done1, pass1;
    logic [15:0] tbl1;
    logic [4:0]  mm1;

    logic [3:0]  abcd_s;
    logic        busy_s, done_s, pass_s;
    logic [15:0] tbl_s;
    logic [4:0]  mm_s;

    always #5 clk = ~clk;

    // ymode: 0 = real SOP, 1 = y stuck at 0, 2 = y stuck at 1
    assign y0 = (ymode == 0) ? ((a0 & ~c0) | (b0 & ~c0 & ~d0) | (a0 & b0 & ~d0)) : (ymode == 2);
    assign y1 = (ymode == 0) ? ((a1 & ~c1) | (b1 & ~c1 & ~d1) | (a1 & b1 & ~d1)) : (ymode == 2);

    sop_sweep_checker #(.SETTLE_CYCLES(1), .EXPECTED(16'h7310)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .a(a0), .b(b0), .c(c0), .d(d0), .y_in(y0),
        .busy(busy0), .done(done0), .table_out(tbl0), .mismatch_cnt(mm0), .pass(pass0)
    );

    sop_sweep_checker #(.SETTLE_CYCLES(0), .EXPECTED(16'h7310)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a(a1), .b(b1), .c(c1), .d(d1), .y_in(y1),
        .busy(busy1), .done(done1), .table_out(tbl1), .mismatch_cnt(mm1), .pass(pass1)
    );

    assign abcd_s = (sel == 0) ? {a0, b0, c0, d0} : {a1, b1, c1, d1};
    assign busy_s = (sel == 0) ? busy0 : busy1;
    assign done_s = (sel == 0) ? done0 : done1;
    assign pass_s = (sel == 0) ? pass0 : pass1;
    assign tbl_s  = (sel == 0) ? tbl0  : tbl1;
    assign mm_s   = (sel == 0) ? mm0   : mm1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) start0 = v;
        else          start1 = v;
    endtask

    task automatic launch();
        set_start(1'b1);
        step();
        set_start(1'b0);
    endtask

    // Counts edges after the accepting edge until done; optionally re-pulses start at step repulse_k
    task automatic wait_done(input int settle, input int repulse_k, input bit chk_ad);
        int k;
        int total;
        k     = 0;
        total = 16 * (settle + 1);
        check("busy_launch", {31'd0, busy_s}, 32'd1);
        check("abcd_first", {28'd0, abcd_s}, 32'd0);
        while (!done_s && k < total + 20) begin
            if (k == repulse_k) set_start(1'b1);
            step();
            set_start(1'b0);
            k++;
            if (chk_ad && k < total) check("abcd_step", {28'd0, abcd_s}, k / (settle + 1));
        end
        check("done_latency", k, total);
    endtask

    task automatic check_results(input logic [15:0] tbl, input logic [4:0] mm, input logic p);
        check("done_pulse", {31'd0, done_s}, 32'd1);
        check("busy_at_done", {31'd0, busy_s}, 32'd0);
        check("table_out", {16'd0, tbl_s}, {16'd0, tbl});
        check("mismatch_cnt", {27'd0, mm_s}, {27'd0, mm});
        check("pass", {31'd0, pass_s}, {31'd0, p});
        check("abcd_hold", {28'd0, abcd_s}, 32'd15);
    endtask

    task automatic check_after(input logic [15:0] tbl, input logic p);
        step();
        check("done_one_cycle", {31'd0, done_s}, 32'd0);
        check("table_held", {16'd0, tbl_s}, {16'd0, tbl});
        check("pass_held", {31'd0, pass_s}, {31'd0, p});
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_abcd"}, {28'd0, abcd_s}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_s}, 32'd0);
        check({tag, "_done"}, {31'd0, done_s}, 32'd0);
        check({tag, "_table"}, {16'd0, tbl_s}, 32'd0);
        check({tag, "_mm"}, {27'd0, mm_s}, 32'd0);
        check({tag, "_pass"}, {31'd0, pass_s}, 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        ymode  = 0;
        sel    = 0;
        #12;
        check_cleared("rst0");
        sel = 1;
        check_cleared("rst1");
        step();
        rst = 1'b0;
        step();

        // 1: real SOP, default settle
        sel = 0; ymode = 0;
        launch();
        wait_done(1, -1, 1'b1);
        check_results(16'h7310, 5'd0, 1'b1);
        check_after(16'h7310, 1'b1);

        // 2: y stuck at 0
        ymode = 1;
        launch();
        wait_done(1, -1, 1'b0);
        check_results(16'h0000, 5'd6, 1'b0);
        check_after(16'h0000, 1'b0);

        // 3: y stuck at 1
        ymode = 2;
        launch();
        wait_done(1, -1, 1'b0);
        check_results(16'hFFFF, 5'd10, 1'b0);
        check_after(16'hFFFF, 1'b0);

        // 4: zero settle, real SOP
        sel = 1; ymode = 0;
        launch();
        wait_done(0, -1, 1'b1);
        check_results(16'h7310, 5'd0, 1'b1);
        check_after(16'h7310, 1'b1);

        // 5a: start re-pulsed while vector 5 is applied is ignored
        sel = 0;
        launch();
        wait_done(1, 10, 1'b1);
        check_results(16'h7310, 5'd0, 1'b1);

        // 5b: start held through DONE relaunches from IDLE
        set_start(1'b1);
        step();
        check("relaunch_idle_busy", {31'd0, busy_s}, 32'd0);
        check("relaunch_idle_done", {31'd0, done_s}, 32'd0);
        step();
        check("relaunch_busy", {31'd0, busy_s}, 32'd1);
        check("relaunch_pass_clr", {31'd0, pass_s}, 32'd0);
        set_start(1'b0);
        wait_done(1, -1, 1'b0);
        check_results(16'h7310, 5'd0, 1'b1);
        check_after(16'h7310, 1'b1);

        // 6: async reset while vector 7 is applied
        ymode = 1;
        launch();
        repeat (14) step();
        check("pre_rst_abcd", {28'd0, abcd_s}, 32'd7);
        #3;
        rst = 1'b1;
        #1;
        check_cleared("mid_rst");
        repeat (3) begin
            step();
            check("rst_no_done", {31'd0, done_s}, 32'd0);
        end
        rst = 1'b0;
        step();
        ymode = 0;
        launch();
        wait_done(1, -1, 1'b0);
        check_results(16'h7310, 5'd0, 1'b1);
        check_after(16'h7310, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sop_sweep_checker.md
Name: sop_sweep_checker

Overview:
Sequential stimulus/capture stage wrapped around the 4-input NAND-only SOP block, y = a&~c | b&~c&~d | a&b&~d. On start it drives all 16 input combinations into the SOP block's a,b,c,d inputs and samples its y output for each one. It assembles a 16-bit truth table and compares it bit-by-bit against an expected mask. It then reports the mismatch count and a pass flag, for board-level self-test of the combinational stage.

Parameters:
SETTLE_CYCLES, 1, extra cycles each vector is held before y is sampled (legal range 0..15)
EXPECTED, 16'h7310, golden truth table; bit n is y for n = {a,b,c,d} with a as the MSB

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a sweep; sampled only in IDLE
a  output  1  stimulus bit 3 of the vector index, to the SOP block
b  output  1  stimulus bit 2
c  output  1  stimulus bit 1
d  output  1  stimulus bit 0
y_in  input  1  y output of the SOP block
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when the sweep completes
table_out  output  16  captured truth table; bit n = y for vector n
mismatch_cnt  output  5  number of bits where table_out differs from EXPECTED (0..16)
pass  output  1  high after done when mismatch_cnt==0; held until the next start

Behaviour:
- Reset (async, any time, including mid-sweep): state=IDLE. a,b,c,d,busy,done,pass=0; table_out=0; mismatch_cnt=0; internal index and settle counters=0. No partial result survives.
- FSM states: IDLE, APPLY, DONE.
- IDLE: start=1 at edge E0 causes the following, all at E0:
  - state goes to APPLY;
  - index=0 and {a,b,c,d}=4'b0000;
  - busy=1, pass=0, table_out=0, mismatch_cnt=0;
  - settle counter=0.
- APPLY: the current vector is held on a..d for exactly SETTLE_CYCLES+1 cycles. The settle counter increments each cycle. At the edge where counter==SETTLE_CYCLES:
  - y_in is captured into table_out[index];
  - if y_in != EXPECTED[index], mismatch_cnt increments by 1;
  - if index<15: index increments, a..d update to the new index at the same edge, counter resets to 0;
  - if index==15: state goes to DONE, busy=0, done=1, pass=(final mismatch_cnt==0). Pass must account for the mismatch on vector 15.
- DONE: lasts one cycle. done returns to 0 and the state goes to IDLE. a..d hold 4'b1111 until the next start.
- Latency: done is high in the cycle following edge E0+16*(SETTLE_CYCLES+1). That is edge 32 for the default, edge 16 for SETTLE_CYCLES=0.
- start is ignored while busy or in DONE. No queuing: a start held high during DONE is not seen until IDLE, and relaunches on the first IDLE edge.
- table_out, mismatch_cnt and pass are stable and readable from done until the next accepted start.
- mismatch_cnt is 5 bits wide so that 16 does not wrap. The index counter is 4 bits and never wraps past 15 in APPLY.
- y_in is treated as synchronous to clk; no synchronizer is included.

Test Plan:
1. Real SOP block connected, default parameters, start pulsed at E0 -> done pulses in the cycle after E0+32, table_out=16'h7310, mismatch_cnt=0, pass=1. a..d step 0..15, each held 2 cycles.
2. y_in tied to 0 -> table_out=16'h0000, mismatch_cnt=6, pass=0.
3. y_in tied to 1 -> table_out=16'hFFFF, mismatch_cnt=10, pass=0.
4. SETTLE_CYCLES=0 with the real block -> a..d change every cycle, done in the cycle after E0+16, table_out=16'h7310, pass=1.
5. start re-pulsed at vector 5 mid-sweep -> ignored: same done timing and results as scenario 1. start held high through DONE -> a second sweep launches from IDLE.
6. rst asserted asynchronously (between edges) while the index is 7 -> all outputs 0 immediately, busy=0, no done. A new start then completes with scenario 1 values.
